// File: rtl/mtr_drv.sv
// mtr_drv: motor-drive output stage. Turns signed left/right wheel speed
// commands into deadtime-protected complementary PWM pairs for two
// H-bridges, with duty double-buffered at PWM period boundaries.
// Optional feature macro: MTR_DRV_OVR_I_EN. When defined, over-current
// blanking, per-period counting and latched shutdown are built in. When
// undefined, the over-current inputs are ignored and OVR_I_shtdwn is tied 0.
module mtr_drv #(
  parameter int DEAD_CYC    = 32,   // 1..63
  parameter int BLANK_CYC   = 128,
  parameter int OVR_I_LIMIT = 10    // 1..15
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic signed [11:0] lft_spd,
  input  logic signed [11:0] rght_spd,
  input  logic               OVR_I_lft,
  input  logic               OVR_I_rght,
  output logic               PWM1_lft,
  output logic               PWM2_lft,
  output logic               PWM1_rght,
  output logic               PWM2_rght,
  output logic               OVR_I_shtdwn
);

  localparam int                 DEAD_W   = 6;
  localparam logic [10:0]        CNT_LAST = 11'd2047;
  localparam logic [10:0]        DUTY_MID = 11'd1024;
  localparam logic signed [11:0] SPD_MAX  = 12'sd1023;
  localparam logic signed [11:0] SPD_MIN  = -12'sd1024;

  // Channel index 0 is the left bridge, 1 is the right bridge.
  logic [10:0]            cnt_q, cnt_d;
  logic [1:0][10:0]       duty_q, duty_d;
  logic [1:0]             pwm_q, pwm_d;
  logic [1:0][DEAD_W-1:0] dead_q, dead_d;
  logic [1:0]             pwm1_q, pwm1_d;
  logic [1:0]             pwm2_q, pwm2_d;
  logic                   shtdwn_d;
  logic                   boundary;

  assign boundary = (cnt_q == CNT_LAST);

  // Clip speed to [-1024, 1023] and offset by 1024; flipping bit 10 of the
  // clipped 11-bit two's-complement value performs the +1024.
  function automatic logic [10:0] to_duty(input logic signed [11:0] spd);
    logic signed [11:0] sat;
    if (spd > SPD_MAX)      sat = SPD_MAX;
    else if (spd < SPD_MIN) sat = SPD_MIN;
    else                    sat = spd;
    return {~sat[10], sat[9:0]};
  endfunction

  // Next-state for counter, duty buffers, internal PWM, deadtime and outputs.
  always_comb begin
    // NOTE: every variable gets a default before any branch, so no latch is inferred.
    cnt_d  = cnt_q + 11'd1;
    duty_d = duty_q;
    pwm_d  = '0;
    dead_d = dead_q;
    pwm1_d = '0;
    pwm2_d = '0;
    if (boundary) begin
      duty_d[0] = to_duty(lft_spd);
      duty_d[1] = to_duty(rght_spd);
    end
    for (int ch = 0; ch < 2; ch++) begin
      pwm_d[ch] = (cnt_q < duty_q[ch]);
      // Any edge of the internal level restarts the deadtime window.
      if (pwm_d[ch] != pwm_q[ch])  dead_d[ch] = DEAD_W'(DEAD_CYC);
      else if (dead_q[ch] != '0)   dead_d[ch] = dead_q[ch] - DEAD_W'(1);
      pwm1_d[ch] =  pwm_d[ch] && (dead_d[ch] == '0) && !shtdwn_d;
      pwm2_d[ch] = !pwm_d[ch] && (dead_d[ch] == '0) && !shtdwn_d;
    end
  end

  // PWM datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: reset is sampled on the clock edge only; rst_n is not in the sensitivity list.
    if (!rst_n) begin
      cnt_q  <= '0;
      duty_q <= {DUTY_MID, DUTY_MID};
      pwm_q  <= '0;
      dead_q <= '0;
      pwm1_q <= '0;
      pwm2_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register sees pre-edge values.
      cnt_q  <= cnt_d;
      duty_q <= duty_d;
      pwm_q  <= pwm_d;
      dead_q <= dead_d;
      pwm1_q <= pwm1_d;
      pwm2_q <= pwm2_d;
    end
  end

  assign PWM1_lft  = pwm1_q[0];
  assign PWM2_lft  = pwm2_q[0];
  assign PWM1_rght = pwm1_q[1];
  assign PWM2_rght = pwm2_q[1];

`ifdef MTR_DRV_OVR_I_EN
  localparam int HI_W = $clog2(BLANK_CYC + 1);

  logic [1:0][HI_W-1:0] hi_q, hi_d;     // clocks PWM1 has already been high
  logic                 flag_q, flag_d;
  logic [3:0]           ocnt_q, ocnt_d;
  logic                 shtdwn_q;
  logic                 ovr_vld;

  // Blanking, per-period flag, consecutive-period counter and sticky shutdown.
  always_comb begin
    hi_d = '0;
    for (int ch = 0; ch < 2; ch++) begin
      if (pwm1_q[ch])
        hi_d[ch] = (hi_q[ch] == HI_W'(BLANK_CYC)) ? hi_q[ch] : hi_q[ch] + HI_W'(1);
    end
    ovr_vld = (pwm1_q[0] && (hi_q[0] == HI_W'(BLANK_CYC)) && OVR_I_lft) ||
              (pwm1_q[1] && (hi_q[1] == HI_W'(BLANK_CYC)) && OVR_I_rght);
    flag_d = flag_q || ovr_vld;
    ocnt_d = ocnt_q;
    if (boundary) begin
      // A valid sample on the closing cycle still belongs to this period.
      flag_d = 1'b0;
      if (flag_q || ovr_vld) ocnt_d = (ocnt_q == 4'hF) ? ocnt_q : ocnt_q + 4'd1;
      else                   ocnt_d = '0;
    end
    shtdwn_d = shtdwn_q || (ocnt_d >= 4'(OVR_I_LIMIT));
  end

  // Over-current state registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hi_q     <= '0;
      flag_q   <= 1'b0;
      ocnt_q   <= '0;
      shtdwn_q <= 1'b0;
    end else begin
      hi_q     <= hi_d;
      flag_q   <= flag_d;
      ocnt_q   <= ocnt_d;
      shtdwn_q <= shtdwn_d;
    end
  end

  assign OVR_I_shtdwn = shtdwn_q;
`else
  logic unused_ovr;
  assign unused_ovr   = OVR_I_lft ^ OVR_I_rght;
  assign shtdwn_d     = 1'b0;
  assign OVR_I_shtdwn = 1'b0;
`endif

endmodule
